// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared constants and helpers for the memory bus arbiter
//
// Purpose: state encoding, requester index constants and a clog2 helper
//          shared by mem_bus_arbiter and rr_picker.
// Ports:   none (package).
package mem_bus_arbiter_pkg;

    // Arbiter state encoding
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] ACK    = 2'd2;

    // Requester slots
    localparam int REQ_FETCH = 0;
    localparam int REQ_DATA  = 1;
    localparam int REQ_IO    = 2;

    // Smallest r with 2**r >= v
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// rtl/mem_bus_arbiter_rr_picker.sv - combinational round-robin winner select
//
// Purpose: scans req starting at rr_ptr, wrapping mod NREQ, and returns the
//          first set bit as a one-hot vector plus its binary index.
// Ports:   req     - request levels
//          rr_ptr  - highest-priority index this round (must be < NREQ)
//          winner  - one-hot winner (all zero when req == 0)
//          win_idx - binary index of winner (0 when req == 0)
module rr_picker #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] winner,
    output logic [PW-1:0]   win_idx
);

    always_comb begin
        int  idx;
        logic found;
        winner  = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            // Explicit wrap: NREQ need not be a power of two
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                win_idx     = PW'(idx);
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one memory port among NREQ masters
//
// Purpose: one transaction at a time; the winner's request is latched, driven
//          on the memory port for WAIT+1 cycles, read data is captured, and a
//          one-cycle ack returns to the winner, followed by one idle cycle.
// Ports:   clk, reset (async, active-low)
//          req/req_wen/req_addr/req_wdata - per-requester request (flattened buses)
//          gnt   - one-hot grant, high during ACCESS and ACK
//          ack   - one-hot completion pulse
//          rdata - data of the last completed read
//          mem_en/mem_wen/mem_addr/mem_wdata/mem_rdata - memory port
//          busy  - transaction in progress
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int WAIT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_wen,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      rdata,
    output logic               mem_en,
    output logic               mem_wen,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata,
    output logic               busy
);

    localparam int PW = (NREQ > 1) ? clog2(NREQ) : 1;

    logic [1:0]      state;
    logic [NREQ-1:0] gnt_q;
    logic [PW-1:0]   idx_q;
    logic [PW-1:0]   rr_ptr;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic            wen_q;
    logic [3:0]      wait_cnt;
    logic [DW-1:0]   rdata_q;

    logic [NREQ-1:0] winner;
    logic [PW-1:0]   win_idx;

    rr_picker #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_picker (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .win_idx (win_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            gnt_q    <= '0;
            idx_q    <= '0;
            rr_ptr   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wen_q    <= 1'b0;
            wait_cnt <= '0;
            rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt_q    <= winner;
                        idx_q    <= win_idx;
                        addr_q   <= req_addr[int'(win_idx)*AW +: AW];
                        wdata_q  <= req_wdata[int'(win_idx)*DW +: DW];
                        wen_q    <= req_wen[win_idx];
                        wait_cnt <= 4'(WAIT);
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        if (!wen_q) begin
                            rdata_q <= mem_rdata;
                        end
                        state <= ACK;
                    end
                end
                ACK: begin
                    rr_ptr <= (int'(idx_q) == NREQ - 1) ? '0 : idx_q + 1'b1;
                    gnt_q  <= '0;
                    state  <= IDLE;
                end
                default: begin
                    gnt_q <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory outputs decode from state so an async reset drops them at once,
    // and the bus is zeroed outside ACCESS.
    assign mem_en    = (state == ACCESS);
    assign mem_wen   = (state == ACCESS) && wen_q;
    assign mem_addr  = (state == ACCESS) ? addr_q : '0;
    assign mem_wdata = (state == ACCESS) ? wdata_q : '0;
    assign ack       = (state == ACK) ? gnt_q : '0;
    assign gnt       = gnt_q;
    assign rdata     = rdata_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter (WAIT=2 and WAIT=0 builds)
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  req       [2];
    logic [2:0]  req_wen   [2];
    logic [95:0] req_addr  [2];
    logic [95:0] req_wdata [2];
    logic [31:0] mem_rdata;

    logic [2:0]  gnt       [2];
    logic [2:0]  ack       [2];
    logic [31:0] rdata     [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic        mem_en    [2];
    logic        mem_wen   [2];
    logic        busy      [2];

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(.NREQ(3), .AW(32), .DW(32), .WAIT(2)) u_dut_w2 (
        .clk       (clk),
        .reset     (reset),
        .req       (req[0]),
        .req_wen   (req_wen[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
        .gnt       (gnt[0]),
        .ack       (ack[0]),
        .rdata     (rdata[0]),
        .mem_en    (mem_en[0]),
        .mem_wen   (mem_wen[0]),
        .mem_addr  (mem_addr[0]),
        .mem_wdata (mem_wdata[0]),
        .mem_rdata (mem_rdata),
        .busy      (busy[0])
    );

    mem_bus_arbiter #(.NREQ(3), .AW(32), .DW(32), .WAIT(0)) u_dut_w0 (
        .clk       (clk),
        .reset     (reset),
        .req       (req[1]),
        .req_wen   (req_wen[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
        .gnt       (gnt[1]),
        .ack       (ack[1]),
        .rdata     (rdata[1]),
        .mem_en    (mem_en[1]),
        .mem_wen   (mem_wen[1]),
        .mem_addr  (mem_addr[1]),
        .mem_wdata (mem_wdata[1]),
        .mem_rdata (mem_rdata),
        .busy      (busy[1])
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Transaction-level reference: each access occupies offsets 0..W on the
    // memory port, offset W+1 is the ack cycle, then one idle cycle follows.
    int          W [2] = '{2, 0};
    bit          m_active [2];
    int          m_t      [2];
    int          m_idx    [2];
    int          m_rr     [2];
    bit          m_wen    [2];
    logic [31:0] m_addr   [2];
    logic [31:0] m_wdata  [2];
    logic [31:0] m_rdata  [2];

    always @(posedge clk or negedge reset) begin : model
        int pick;
        if (!reset) begin
            for (int m = 0; m < 2; m++) begin
                m_active[m] = 1'b0;
                m_t[m]      = 0;
                m_idx[m]    = 0;
                m_rr[m]     = 0;
                m_wen[m]    = 1'b0;
                m_addr[m]   = '0;
                m_wdata[m]  = '0;
                m_rdata[m]  = '0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (m_active[m]) begin
                    if (m_t[m] == W[m] + 1) begin
                        m_rr[m]     = (m_idx[m] + 1) % 3;
                        m_active[m] = 1'b0;
                    end else begin
                        if (m_t[m] == W[m] && !m_wen[m]) m_rdata[m] = mem_rdata;
                        m_t[m] = m_t[m] + 1;
                    end
                end else if (req[m] != 3'b000) begin
                    pick = -1;
                    for (int k = 0; k < 3; k++) begin
                        if (pick < 0 && req[m][(m_rr[m] + k) % 3]) pick = (m_rr[m] + k) % 3;
                    end
                    m_idx[m]    = pick;
                    m_wen[m]    = req_wen[m][pick];
                    m_addr[m]   = req_addr[m][pick*32 +: 32];
                    m_wdata[m]  = req_wdata[m][pick*32 +: 32];
                    m_active[m] = 1'b1;
                    m_t[m]      = 0;
                end
            end
        end
    end

    function automatic bit model_ack(input int m, input int i);
        return m_active[m] && (m_t[m] == W[m] + 1) && (m_idx[m] == i);
    endfunction

    // Every-cycle comparison against the model
    always @(negedge clk) begin : compare
        bit          acc;
        bit          ackp;
        logic [2:0]  e_gnt;
        for (int m = 0; m < 2; m++) begin
            acc   = m_active[m] && (m_t[m] <= W[m]);
            ackp  = m_active[m] && (m_t[m] == W[m] + 1);
            e_gnt = m_active[m] ? 3'(1 << m_idx[m]) : 3'b000;
            check($sformatf("gnt%0d", m),       {61'd0, gnt[m]}, {61'd0, e_gnt});
            check($sformatf("ack%0d", m),       {61'd0, ack[m]}, {61'd0, ackp ? e_gnt : 3'b000});
            check($sformatf("mem_en%0d", m),    {63'd0, mem_en[m]}, {63'd0, acc});
            check($sformatf("mem_wen%0d", m),   {63'd0, mem_wen[m]}, {63'd0, acc && m_wen[m]});
            check($sformatf("mem_addr%0d", m),  {32'd0, mem_addr[m]}, {32'd0, acc ? m_addr[m] : 32'd0});
            check($sformatf("mem_wdata%0d", m), {32'd0, mem_wdata[m]}, {32'd0, acc ? m_wdata[m] : 32'd0});
            check($sformatf("rdata%0d", m),     {32'd0, rdata[m]}, {32'd0, m_rdata[m]});
            check($sformatf("busy%0d", m),      {63'd0, busy[m]}, {63'd0, m_active[m]});
        end
    end

    task automatic dir_txn(input int m, input int i, input bit wen, input logic [31:0] addr,
                           input logic [31:0] wd, output int en_cnt, output int ack_k,
                           output logic [2:0] ack_v, output logic busy_after);
        req_wen[m][i]          = wen;
        req_addr[m][i*32 +: 32]  = addr;
        req_wdata[m][i*32 +: 32] = wd;
        req[m][i]              = 1'b1;
        en_cnt     = 0;
        ack_k      = -1;
        ack_v      = 3'b000;
        busy_after = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            #1;
            if (mem_en[m] && mem_addr[m] == addr && mem_wen[m] == wen && mem_wdata[m] == wd) en_cnt++;
            if (ack_k > 0 && k == ack_k + 1) busy_after = busy[m];
            if (ack[m] != 3'b000 && ack_k < 0) begin
                ack_k     = k;
                ack_v     = ack[m];
                req[m][i] = 1'b0;
            end
        end
    endtask

    initial begin : main
        int          en_cnt;
        int          ack_k;
        logic [2:0]  ack_v;
        logic        busy_after;
        int          seq  [6];
        int          when [6];
        int          n;
        logic [2:0]  g;
        for (int m = 0; m < 2; m++) begin
            req[m]       = '0;
            req_wen[m]   = '0;
            req_addr[m]  = '0;
            req_wdata[m] = '0;
        end
        mem_rdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt",   {61'd0, gnt[0]}, 64'd0);
        check("rst_mem_en", {63'd0, mem_en[0]}, 64'd0);
        check("rst_rdata", {32'd0, rdata[0]}, 64'd0);
        check("rst_busy",  {63'd0, busy[0]}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single read from requester 1
        mem_rdata = 32'hDEADBEEF;
        dir_txn(0, 1, 1'b0, 32'h10, 32'h0, en_cnt, ack_k, ack_v, busy_after);
        check("rd_en_cycles", 64'(en_cnt), 64'd3);
        check("rd_ack",       {61'd0, ack_v}, 64'b010);
        check("rd_latency",   64'(ack_k), 64'd4);
        check("rd_busy_after", {63'd0, busy_after}, 64'd0);
        check("rd_rdata",     {32'd0, rdata[0]}, 64'hDEADBEEF);

        // Write from requester 2
        mem_rdata = 32'hBAD0BAD0;
        dir_txn(0, 2, 1'b1, 32'h20, 32'h1234, en_cnt, ack_k, ack_v, busy_after);
        check("wr_en_cycles", 64'(en_cnt), 64'd3);
        check("wr_ack",       {61'd0, ack_v}, 64'b100);
        check("wr_rdata_kept", {32'd0, rdata[0]}, 64'hDEADBEEF);

        // Round-robin with all requesters held
        req_wen[0] = 3'b000;
        req[0]     = 3'b111;
        n = 0;
        for (int j = 0; j < 6; j++) begin seq[j] = -1; when[j] = 0; end
        for (int k = 0; k < 40 && n < 6; k++) begin
            @(negedge clk);
            #1;
            if (ack[0] != 3'b000) begin
                seq[n]  = (ack[0] == 3'b001) ? 0 : (ack[0] == 3'b010) ? 1 : (ack[0] == 3'b100) ? 2 : 9;
                when[n] = k;
                n++;
                if (n == 6) req[0] = 3'b000;
            end
        end
        req[0] = 3'b000;
        for (int j = 0; j < 6; j++) begin
            check($sformatf("rr_order%0d", j), 64'(seq[j]), 64'(j % 3));
            if (j > 0) check($sformatf("rr_spacing%0d", j), 64'(when[j] - when[j-1]), 64'd5);
        end

        // Latched request survives req drop and address change
        @(negedge clk);
        req_addr[0][31:0] = 32'h100;
        req[0][0] = 1'b1;
        en_cnt = 0;
        for (int k = 0; k < 5 && en_cnt == 0; k++) begin
            @(negedge clk);
            #1;
            if (mem_en[0] && mem_addr[0] == 32'h100) en_cnt = 1;
        end
        req[0][0] = 1'b0;
        req_addr[0][31:0] = 32'hFFFF;
        ack_v = 3'b000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            if (mem_en[0] && mem_addr[0] == 32'h100) en_cnt++;
            if (ack[0] != 3'b000) ack_v = ack[0];
        end
        check("stab_en_cycles", 64'(en_cnt), 64'd3);
        check("stab_ack", {61'd0, ack_v}, 64'b001);
        // rr_ptr now 1: requester 1 must beat requester 0
        req[0] = 3'b011;
        ack_v = 3'b000;
        for (int k = 0; k < 8 && ack_v == 3'b000; k++) begin
            @(negedge clk);
            #1;
            if (ack[0] != 3'b000) begin ack_v = ack[0]; req[0] = 3'b000; end
        end
        req[0] = 3'b000;
        check("stab_rr_next", {61'd0, ack_v}, 64'b010);

        // Reset in the second ACCESS cycle
        @(negedge clk);
        req[0][2] = 1'b1;
        n = 0;
        for (int k = 0; k < 5 && n == 0; k++) begin
            @(negedge clk);
            #1;
            if (mem_en[0]) n = 1;
        end
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_mem_en", {63'd0, mem_en[0]}, 64'd0);
        check("arst_gnt",    {61'd0, gnt[0]}, 64'd0);
        check("arst_ack",    {61'd0, ack[0]}, 64'd0);
        check("arst_rdata",  {32'd0, rdata[0]}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        g = 3'b000;
        for (int k = 0; k < 5 && g == 3'b000; k++) begin
            @(negedge clk);
            #1;
            g = gnt[0];
        end
        check("arst_regrant", {61'd0, g}, 64'b100);
        for (int k = 0; k < 8 && req[0][2]; k++) begin
            @(negedge clk);
            #1;
            if (ack[0] != 3'b000) req[0][2] = 1'b0;
        end
        req[0] = 3'b000;

        // WAIT=0 build
        mem_rdata = 32'hCAFE0001;
        dir_txn(1, 0, 1'b0, 32'h44, 32'h0, en_cnt, ack_k, ack_v, busy_after);
        check("w0_en_cycles", 64'(en_cnt), 64'd1);
        check("w0_latency",   64'(ack_k), 64'd2);
        check("w0_ack",       {61'd0, ack_v}, 64'b001);
        check("w0_rdata",     {32'd0, rdata[1]}, 64'hCAFE0001);

        // Randomized traffic on both builds, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            mem_rdata = $urandom;
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < 3; i++) begin
                    if (!req[m][i]) begin
                        if ($urandom_range(2) == 0) begin
                            req[m][i]                = 1'b1;
                            req_wen[m][i]            = 1'($urandom_range(1));
                            req_addr[m][i*32 +: 32]  = $urandom;
                            req_wdata[m][i*32 +: 32] = $urandom;
                        end
                    end else if (model_ack(m, i)) begin
                        if ($urandom_range(3) != 0) req[m][i] = 1'b0;
                        else req_addr[m][i*32 +: 32] = $urandom;
                    end else if ($urandom_range(3) == 0) begin
                        req_addr[m][i*32 +: 32]  = $urandom;
                        req_wdata[m][i*32 +: 32] = $urandom;
                    end
                end
            end
        end
        for (int m = 0; m < 2; m++) req[m] = 3'b000;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory port (addr/data bus, MemEn/MemWen) between NREQ requesters: CPU instruction fetch, CPU load/store, and an IO/DMA master.
- Arbitration is round-robin. One transaction is in flight at a time.
- Each transaction drives the memory for a fixed WAIT-state window, captures the read data, then returns a one-cycle ack to the granted requester.
- Sits between the CPU's bus-master logic and the memory/IO slave.

Parameters:
- NREQ, 3, number of requesters (index 0 = fetch, 1 = CPU data, 2 = IO/DMA); valid range 2..8
- AW, 32, address width
- DW, 32, data width
- WAIT, 2, extra memory wait cycles per access (0 = single-cycle memory); valid range 0..15

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level; held high until that requester's ack
- req_wen  in  NREQ  per-requester write enable (1 = write, 0 = read)
- req_addr  in  NREQ*AW  flattened addresses; requester i uses bits [i*AW +: AW]
- req_wdata  in  NREQ*DW  flattened write data, same packing as req_addr
- gnt  out  NREQ  one-hot grant; high during ACCESS and ACK
- ack  out  NREQ  one-hot, one-cycle completion pulse
- rdata  out  DW  read data of last completed read; held until the next read completes
- mem_en  out  1  memory enable (MemEn)
- mem_wen  out  1  memory write enable (MemWen)
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- busy  out  1  high when state is not IDLE

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While reset is low, all outputs are 0, state = IDLE, rr_ptr = 0, wait_cnt = 0.
- Reset asserted mid-transaction aborts it immediately: no ack, memory outputs drop asynchronously.
- States: IDLE, ACCESS, ACK.
- IDLE:
  - mem_en = 0 and gnt = 0.
  - If any req bit is set, pick the first set bit scanning rr_ptr, rr_ptr+1, … mod NREQ.
  - At the clock edge: register gnt one-hot; latch addr, wdata and wen of the winner; wait_cnt <= WAIT; go to ACCESS.
- ACCESS:
  - mem_en = 1; mem_wen, mem_addr and mem_wdata come from the latched registers and stay stable for the whole state.
  - If wait_cnt != 0, decrement it and stay. If wait_cnt == 0, go to ACK.
  - On the ACCESS->ACK transition of a read, rdata <= mem_rdata. Writes leave rdata unchanged.
  - ACCESS therefore lasts exactly WAIT+1 cycles.
- ACK:
  - mem_en = 0, mem_wen = 0, ack = gnt for exactly one cycle.
  - rr_ptr <= (granted index + 1) mod NREQ.
  - Next state is IDLE unconditionally, giving one idle cycle between transactions.
- Latency: a request sampled at edge E0 has its ack high in the cycle after edge E0+WAIT+1. Throughput is one transaction per WAIT+3 cycles.
- Requester contract: deassert req in the cycle after ack. A req still high when back in IDLE is a new request, arbitrated at the rotated priority.
- Request changes after grant: req dropping or addr/wdata changing after grant does not affect the in-flight access (latched values are used). The access completes and ack still pulses.
- Simultaneous requests: all resolved by rr_ptr, so no requester waits more than NREQ-1 transactions.
- mem_addr and mem_wdata are 0 whenever not in ACCESS, so the bus is never driven with stale values.
- Index arithmetic: rr_ptr is clog2(NREQ) bits wide. Wrap is explicit mod NREQ, never a natural binary overflow, since NREQ may be a non-power-of-2.

Decomposition:
- Shared package: state encoding localparams (IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2), a clog2 function, and requester index constants (REQ_FETCH = 0, REQ_DATA = 1, REQ_IO = 2).
- One sub-module, rr_picker: combinational; inputs req and rr_ptr; outputs a one-hot winner and its binary index.
- The FSM, latches and wait counter stay in the top module.

Test Plan:
- Single read: WAIT=2, only req[1] high with addr 0x10, mem_rdata = 0xDEADBEEF -> mem_en high for 3 cycles with mem_addr 0x10 and mem_wen 0; ack = 3'b010 for one cycle; rdata = 0xDEADBEEF; busy low one cycle after the ack cycle.
- Write: req[2] with wen = 1, addr 0x20, wdata 0x1234 -> mem_wen = 1 and mem_wdata = 0x1234 for 3 cycles; rdata unchanged from the prior value; ack = 3'b100.
- Round-robin: all three req held continuously -> grant order 0, 1, 2, 0, 1, 2, …, with gnt one-hot at all times and ack spacing of WAIT+3 = 5 cycles.
- Stability: req[0] granted, then req[0] dropped and req_addr changed during ACCESS -> mem_addr holds the latched value, ack[0] still pulses, rr_ptr advances to 1.
- Reset mid-access: reset driven low in the second ACCESS cycle -> mem_en, gnt, ack and rdata go to 0 immediately, with no ack; after release with req[2] high, requester 2 is granted.
- WAIT=0 build: a single request gives mem_en for exactly 1 cycle and ack in the cycle after the next edge.
